// File: rtl/fu_mult_pipe_if.sv
// Issue-lane / completion-bus bundle for the pipelined multiply unit.
// master = issue FIFO and CDB side, slave = the functional unit.
interface fu_mult_pipe_if #(
  parameter int PR_W  = 6,
  parameter int ROB_W = 5
);
  typedef struct packed {
    logic             valid;
    logic [1:0]       op_sel;
    logic [31:0]      r1_value;
    logic [31:0]      r2_value;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
  } issue_fu_packet_t;

  issue_fu_packet_t fu_pckt_in;
  logic             rd_en;
  logic             complete_grant;
  logic             result_valid;
  logic [31:0]      result_value;
  logic [PR_W-1:0]  result_pr;
  logic [ROB_W-1:0] result_rob;

  modport master (
    output fu_pckt_in, complete_grant,
    input  rd_en, result_valid, result_value, result_pr, result_rob
  );

  modport slave (
    input  fu_pckt_in, complete_grant,
    output rd_en, result_valid, result_value, result_pr, result_rob
  );
endinterface

// File: rtl/fu_mult_pipe.sv
// Multi-stage shift-and-add multiplier (MUL/MULH/MULHSU/MULHU) with whole-pipe stall.
// Optional flush port enabled by defining FU_MULT_SQUASH_EN.
module fu_mult_pipe #(
  parameter int NUM_STAGE = 4,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 5
) (
  input  logic clock,
  input  logic reset,
`ifdef FU_MULT_SQUASH_EN
  input  logic squash,
`endif
  fu_mult_pipe_if.slave bus
);
  localparam int BITS = 64 / NUM_STAGE;
  localparam int LAST = NUM_STAGE - 1;
  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  logic             valid_reg  [NUM_STAGE];
  logic [63:0]      sum_reg    [NUM_STAGE];
  logic [63:0]      mcand_reg  [NUM_STAGE];
  logic [63:0]      mplier_reg [NUM_STAGE];
  logic [1:0]       op_reg     [NUM_STAGE];
  logic [PR_W-1:0]  pr_reg     [NUM_STAGE];
  logic [ROB_W-1:0] rob_reg    [NUM_STAGE];

  logic             valid_next  [NUM_STAGE];
  logic [63:0]      sum_next    [NUM_STAGE];
  logic [63:0]      mcand_next  [NUM_STAGE];
  logic [63:0]      mplier_next [NUM_STAGE];
  logic [1:0]       op_next     [NUM_STAGE];
  logic [PR_W-1:0]  pr_next     [NUM_STAGE];
  logic [ROB_W-1:0] rob_next    [NUM_STAGE];

  logic        stall;
  logic        flush;
  logic [63:0] in_mcand;
  logic [63:0] in_mplier;

  assign stall = valid_reg[LAST] & ~bus.complete_grant;
`ifdef FU_MULT_SQUASH_EN
  assign flush = squash;
`else
  assign flush = 1'b0;
`endif
  assign bus.rd_en = ~reset & ~stall & ~flush;

  // Extending to 64 bits makes the truncated product equal the exact 33x33 product mod 2^64.
  always_comb begin
    in_mcand  = {{32{bus.fu_pckt_in.r1_value[31]}}, bus.fu_pckt_in.r1_value};
    in_mplier = {{32{bus.fu_pckt_in.r2_value[31]}}, bus.fu_pckt_in.r2_value};
    if (bus.fu_pckt_in.op_sel == OP_MULHU)
      in_mcand = {32'd0, bus.fu_pckt_in.r1_value};
    if (bus.fu_pckt_in.op_sel == OP_MULHU || bus.fu_pckt_in.op_sel == OP_MULHSU)
      in_mplier = {32'd0, bus.fu_pckt_in.r2_value};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      logic             src_valid;
      logic [63:0]      src_sum;
      logic [63:0]      src_mcand;
      logic [63:0]      src_mplier;
      logic [1:0]       src_op;
      logic [PR_W-1:0]  src_pr;
      logic [ROB_W-1:0] src_rob;
      logic [63:0]      chunk;

      if (gi == 0) begin : g_head
        assign src_valid  = bus.rd_en & bus.fu_pckt_in.valid;
        assign src_sum    = 64'd0;
        assign src_mcand  = in_mcand;
        assign src_mplier = in_mplier;
        assign src_op     = bus.fu_pckt_in.op_sel;
        assign src_pr     = bus.fu_pckt_in.dest_pr;
        assign src_rob    = bus.fu_pckt_in.rob_entry;
      end else begin : g_body
        assign src_valid  = valid_reg[gi-1];
        assign src_sum    = sum_reg[gi-1];
        assign src_mcand  = mcand_reg[gi-1];
        assign src_mplier = mplier_reg[gi-1];
        assign src_op     = op_reg[gi-1];
        assign src_pr     = pr_reg[gi-1];
        assign src_rob    = rob_reg[gi-1];
      end

      // Each stage consumes the next BITS multiplier bits against the pre-shifted multiplicand.
      assign chunk           = 64'(src_mplier[BITS-1:0]);
      assign valid_next[gi]  = src_valid;
      assign sum_next[gi]    = src_sum + src_mcand * chunk;
      assign mcand_next[gi]  = src_mcand << BITS;
      assign mplier_next[gi] = src_mplier >> BITS;
      assign op_next[gi]     = src_op;
      assign pr_next[gi]     = src_pr;
      assign rob_next[gi]    = src_rob;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        valid_reg[i]  <= 1'b0;
        sum_reg[i]    <= '0;
        mcand_reg[i]  <= '0;
        mplier_reg[i] <= '0;
        op_reg[i]     <= '0;
        pr_reg[i]     <= '0;
        rob_reg[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_STAGE; i++)
        valid_reg[i] <= 1'b0;
    end else if (!stall) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        valid_reg[i]  <= valid_next[i];
        sum_reg[i]    <= sum_next[i];
        mcand_reg[i]  <= mcand_next[i];
        mplier_reg[i] <= mplier_next[i];
        op_reg[i]     <= op_next[i];
        pr_reg[i]     <= pr_next[i];
        rob_reg[i]    <= rob_next[i];
      end
    end
  end

  assign bus.result_valid = valid_reg[LAST];

  always_comb begin
    bus.result_value = 32'd0;
    bus.result_pr    = '0;
    bus.result_rob   = '0;
    if (valid_reg[LAST]) begin
      bus.result_value = (op_reg[LAST] == OP_MUL) ? sum_reg[LAST][31:0] : sum_reg[LAST][63:32];
      bus.result_pr    = pr_reg[LAST];
      bus.result_rob   = rob_reg[LAST];
    end
  end
endmodule

// File: tb/tb_fu_mult_pipe.sv
// Self-checking bench for fu_mult_pipe: slot-level pipeline model checked every cycle,
// plus hand-computed literal results, latency, ordering, stall and reset checks.
module tb_fu_mult_pipe;
  localparam int NS = 4;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int VW = 2 + 32 + PW + RW;
  localparam logic [1:0] MUL = 2'd0, MULH = 2'd1, MULHSU = 2'd2, MULHU = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef FU_MULT_SQUASH_EN
  logic squash = 1'b0;
`endif

  fu_mult_pipe_if #(.PR_W(PW), .ROB_W(RW)) bus ();

  fu_mult_pipe #(.NUM_STAGE(NS), .PR_W(PW), .ROB_W(RW)) dut (
    .clock (clock),
    .reset (reset),
`ifdef FU_MULT_SQUASH_EN
    .squash(squash),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          v;
    logic [31:0]   val;
    logic [PW-1:0] pr;
    logic [RW-1:0] rob;
  } exp_t;

  typedef struct {
    logic [31:0]   val;
    logic [PW-1:0] pr;
    logic [RW-1:0] rob;
    int            c;
  } done_t;

  exp_t  slot [NS];
  done_t done_q [$];
  int    acc_cyc [$];
  int    cyc = 0;
  bit    started = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      MUL:     begin p = sa * sb; return p[31:0];  end
      MULH:    begin p = sa * sb; return p[63:32]; end
      MULHSU:  begin p = sa * ub; return p[63:32]; end
      default: return pu[63:32];
    endcase
  endfunction

  // Model: the whole pipe shifts by one slot unless the tail slot is waiting for a grant.
  always @(posedge clock) begin
    logic stall_m;
    exp_t e;
    stall_m = slot[NS-1].v && !bus.complete_grant;
    if (reset) begin
      for (int i = 0; i < NS; i++) slot[i] = '0;
    end
`ifdef FU_MULT_SQUASH_EN
    else if (squash) begin
      for (int i = 0; i < NS; i++) slot[i] = '0;
    end
`endif
    else if (!stall_m) begin
      e = '0;
      if (bus.fu_pckt_in.valid) begin
        e.v   = 1'b1;
        e.val = ref_mul(bus.fu_pckt_in.op_sel, bus.fu_pckt_in.r1_value, bus.fu_pckt_in.r2_value);
        e.pr  = bus.fu_pckt_in.dest_pr;
        e.rob = bus.fu_pckt_in.rob_entry;
        acc_cyc.push_back(cyc);
      end
      for (int i = NS - 1; i > 0; i--) slot[i] = slot[i-1];
      slot[0] = e;
    end
    cyc++;
    started = 1;
  end

  always @(negedge clock) begin
    logic          exp_rd;
    logic          squashing;
    logic [VW-1:0] got, want;
    done_t         d;
    if (started) begin
      squashing = 1'b0;
`ifdef FU_MULT_SQUASH_EN
      squashing = squash;
`endif
      exp_rd = !reset && !squashing && !(slot[NS-1].v && !bus.complete_grant);
      got  = {bus.rd_en, bus.result_valid, bus.result_value, bus.result_pr, bus.result_rob};
      want = {exp_rd, slot[NS-1].v, slot[NS-1].val, slot[NS-1].pr, slot[NS-1].rob};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle_check cyc=%0d got rd/v/val/pr/rob=%h want=%h", cyc, got, want);
      end
      if (bus.result_valid && bus.complete_grant && !reset && !squashing) begin
        d.val = bus.result_value;
        d.pr  = bus.result_pr;
        d.rob = bus.result_rob;
        d.c   = cyc;
        done_q.push_back(d);
        $display("done cyc=%0d val=%h pr=%0d rob=%0d", cyc, d.val, d.pr, d.rob);
      end
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b, int pr, int rob);
    bus.fu_pckt_in.valid     = 1'b1;
    bus.fu_pckt_in.op_sel    = op;
    bus.fu_pckt_in.r1_value  = a;
    bus.fu_pckt_in.r2_value  = b;
    bus.fu_pckt_in.dest_pr   = PW'(pr);
    bus.fu_pckt_in.rob_entry = RW'(rob);
    step(1);
  endtask

  task automatic idle(int n);
    bus.fu_pckt_in.valid = 1'b0;
    step(n);
  endtask

  initial begin
    int base, a0;
    logic [31:0] va [4];
    logic [1:0]  ops [4];
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    bus.fu_pckt_in      = '0;
    bus.complete_grant  = 1'b0;
    step(3);
    reset = 1'b0;
    check("reset_result_valid", 64'(bus.result_valid), 64'd0);
    check("reset_result_value", 64'(bus.result_value), 64'd0);

    // Single MUL 7*6 with grant held.
    bus.complete_grant = 1'b1;
    base = done_q.size();
    a0   = acc_cyc.size();
    issue(MUL, 32'd7, 32'd6, 5, 3);
    idle(6);
    check("mul7x6_value", 64'(done_q[base].val), 64'd42);
    check("mul7x6_pr",    64'(done_q[base].pr),  64'd5);
    check("mul7x6_rob",   64'(done_q[base].rob), 64'd3);
    check("mul7x6_latency", 64'(done_q[base].c - acc_cyc[a0]), 64'd4);

    // Signed/unsigned high-half corner cases.
    ops = '{MULH, MULHU, MULHSU, MUL};
    ra  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rb  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    va  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
    base = done_q.size();
    for (int i = 0; i < 4; i++) issue(ops[i], ra[i], rb[i], i + 1, i + 1);
    idle(6);
    for (int i = 0; i < 4; i++)
      check($sformatf("corner%0d_value", i), 64'(done_q[base+i].val), 64'(va[i]));

    // Eight back-to-back packets: results on eight consecutive cycles, in order.
    base = done_q.size();
    for (int i = 0; i < 8; i++)
      issue(2'(i), 32'h1234_5678 * (i + 1), 32'hF0F0_0F0F - i * 32'h0101_0101, i + 8, i);
    idle(8);
    check("b2b_count", 64'(done_q.size() - base), 64'd8);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("b2b_gap%0d", i), 64'(done_q[base+i].c - done_q[base+i-1].c), 64'd1);
      check($sformatf("b2b_rob%0d", i), 64'(done_q[base+i].rob), 64'(i));
    end

    // Fill, stall for five cycles with a packet waiting, then drain.
    bus.complete_grant = 1'b0;
    base = done_q.size();
    for (int i = 0; i < 4; i++) issue(MUL, 32'd100 + i, 32'd3, i + 20, i + 10);
    issue(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 33, 20);
    step(4);
    check("stall_rd_en", 64'(bus.rd_en), 64'd0);
    check("stall_hold_rob", 64'(bus.result_rob), 64'd10);
    check("stall_hold_value", 64'(bus.result_value), 64'd300);
    bus.complete_grant = 1'b1;
    idle(6);
    check("drain_count", 64'(done_q.size() - base), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_rob%0d", i), 64'(done_q[base+i].rob), 64'(i + 10));

    // Reset with a full, stalled pipeline discards everything.
    bus.complete_grant = 1'b0;
    base = done_q.size();
    for (int i = 0; i < 4; i++) issue(MUL, 32'd9, 32'd9, i, i + 1);
    idle(2);
    reset = 1'b1;
    step(1);
    check("rst_mid_valid", 64'(bus.result_valid), 64'd0);
    check("rst_mid_outs", {bus.result_value, 8'(bus.result_pr), 8'(bus.result_rob)}, 64'd0);
    check("rst_mid_rd_en", 64'(bus.rd_en), 64'd0);
    reset = 1'b0;
    bus.complete_grant = 1'b1;
    idle(6);
    check("rst_mid_no_done", 64'(done_q.size() - base), 64'd0);

`ifdef FU_MULT_SQUASH_EN
    // Squash three in-flight packets; a packet issued right after completes normally.
    base = done_q.size();
    for (int i = 0; i < 3; i++) issue(MUL, 32'd5, 32'd5, i, i + 7);
    bus.fu_pckt_in.valid = 1'b0;
    squash = 1'b1;
    step(1);
    squash = 1'b0;
    check("squash_valid", 64'(bus.result_valid), 64'd0);
    issue(MUL, 32'd11, 32'd11, 2, 15);
    idle(6);
    check("squash_count", 64'(done_q.size() - base), 64'd1);
    check("squash_new_rob", 64'(done_q[base].rob), 64'd15);
    check("squash_new_value", 64'(done_q[base].val), 64'd121);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fu_mult_pipe.md
FU_MULT_PIPE -- requirements
Module: fu_mult_pipe

Interface
REQ-001 Parameter NUM_STAGE, default 4, number of multiply pipeline stages; legal values 1, 2, 4, 8.
REQ-002 Parameter PR_W, default 6, physical-register tag width.
REQ-003 Parameter ROB_W, default 5, ROB index width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fu_pckt_in  input  ISSUE_FU_PACKET  packet from issue FIFO lane; uses fields valid, op_sel, r1_value[31:0], r2_value[31:0], dest_pr, rob_entry.
REQ-007 rd_en  output  1  request to issue FIFO lane; FIFO returns packet combinationally same cycle.
REQ-008 complete_grant  input  1  CDB grant for the result held in last stage.
REQ-009 result_valid  output  1  last stage holds a finished result.
REQ-010 result_value  output  32  selected 32 bits of product.
REQ-011 result_pr  output  PR_W  destination tag.
REQ-012 result_rob  output  ROB_W  ROB index.
REQ-013 squash  input  1  pipeline flush; present only with FU_MULT_SQUASH_EN.

Function
REQ-014 op_sel encodings: MUL (low 32, signed x signed), MULH (high 32, signed x signed), MULHSU (high 32, signed x unsigned), MULHU (high 32, unsigned x unsigned).
REQ-015 Operands extended to 33 bits per op_sel; product 64 bits, two's complement modulo 2^64.
REQ-016 Each stage accumulates 64/NUM_STAGE bits of multiplier partial product; stage registers carry valid, partial sum, shifted multiplicand, remaining multiplier, op_sel, dest_pr, rob_entry.
REQ-017 Packet accepted on edge where rd_en=1 and fu_pckt_in.valid=1; rd_en=1 with valid=0 accepts nothing and inserts a bubble.
REQ-018 Latency: result_valid asserts NUM_STAGE cycles after acceptance edge when no stall.
REQ-019 Stall = result_valid & ~complete_grant; on stall all stages hold, no acceptance.
REQ-020 rd_en = ~stall (and ~squash when compiled in); combinational, no dependency on fu_pckt_in.
REQ-021 Bubbles collapse: a stage with valid=0 accepts from previous stage even if a later stage is stalled only when all later stages are stalled-full is not required; pipeline advances as a whole (no bubble squeezing).
REQ-022 complete_grant while result_valid=0 ignored.
REQ-023 Throughput: one packet per cycle while complete_grant held high or result_valid low.
REQ-024 result_value/result_pr/result_rob driven 0 when result_valid=0.
REQ-025 Results leave in acceptance order; no packet lost or duplicated across stalls.

Reset
REQ-026 reset clears all stage valid bits and data registers to 0 on next rising edge.
REQ-027 During reset cycle rd_en=0; after reset result_valid=0, result_value=0, result_pr=0, result_rob=0.
REQ-028 Reset mid-stall discards all in-flight packets; complete_grant irrelevant.

Configuration
REQ-029 Macro FU_MULT_SQUASH_EN: defined -> squash port exists; squash=1 forces rd_en=0 that cycle, clears all stage valid bits on that edge, result_valid=0 next cycle, overrides stall and grant.
REQ-030 Macro undefined -> no squash port; pipeline flushed only by reset.

Verification
REQ-031 Reset, then MUL r1=7 r2=6 accepted cycle 0, grant=1 -> cycle 4 result_valid=1, result_value=42, tag/rob match input.
REQ-032 MULH r1=0x80000000 r2=0x80000000 -> 0x40000000; MULHU r1=0xFFFFFFFF r2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU r1=0xFFFFFFFF r2=2 -> 0xFFFFFFFF; MUL r1=0xFFFFFFFF r2=0xFFFFFFFF -> 1.
REQ-033 Back-to-back 8 packets, grant=1 -> 8 consecutive result_valid cycles, in order, rd_en constantly 1.
REQ-034 Pipeline full, grant=0 for 5 cycles -> rd_en=0, outputs stable, then grant=1 drains all 4 in order.
REQ-035 With FU_MULT_SQUASH_EN, 3 in flight, squash pulse -> next cycle result_valid=0, no prior packet ever completes; new packet next cycle completes normally.
REQ-036 Reset asserted with 4 in flight and grant=0 -> result_valid=0 next cycle, all outputs 0.
